// File: rtl/tile_movement_ctrl.sv
// rtl/tile_movement_ctrl.sv - grid-locked tile stepping controller with collision query handshake
module tile_movement_ctrl #(
    parameter int          MAP_W     = 20,
    parameter int          MAP_H     = 15,
    parameter int          TILE_PX   = 16,
    parameter int          STEP_PX   = 2,
    parameter int          START_X   = 10,
    parameter int          START_Y   = 7,
    parameter logic [7:0]  KEY_UP    = 8'h1A,
    parameter logic [7:0]  KEY_LEFT  = 8'h04,
    parameter logic [7:0]  KEY_DOWN  = 8'h16,
    parameter logic [7:0]  KEY_RIGHT = 8'h07
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       frame_clk,
    input  logic [7:0]                 keycode,
    input  logic                       Query_Blocked,
    output logic                       Query_Valid,
    output logic [$clog2(MAP_W)-1:0]   Query_X,
    output logic [$clog2(MAP_H)-1:0]   Query_Y,
    output logic [$clog2(MAP_W)-1:0]   Tile_X,
    output logic [$clog2(MAP_H)-1:0]   Tile_Y,
    output logic [9:0]                 Pixel_X,
    output logic [9:0]                 Pixel_Y,
    output logic [1:0]                 Direction,
    output logic                       Character_Moving,
    output logic                       Anim_Frame
);
    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);
    localparam int OW = $clog2(TILE_PX) + 1;

    localparam logic [XW-1:0] X_MAX    = XW'(MAP_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(MAP_H - 1);
    localparam logic [OW-1:0] OFF_STEP = OW'(STEP_PX);
    localparam logic [OW-1:0] OFF_FULL = OW'(TILE_PX);
    localparam logic [OW-1:0] OFF_HALF = OW'(TILE_PX / 2);
    localparam logic [9:0]    TILE10   = 10'(TILE_PX);

    localparam logic [1:0] DIR_DOWN  = 2'd0;
    localparam logic [1:0] DIR_UP    = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {IDLE, QUERY, CHECK, MOVE} state_e;

    state_e         state_q, state_d;
    logic [2:0]     fc_sync_q;
    logic           tick;
    logic           key_req;
    logic [1:0]     key_dir;
    logic [XW-1:0]  nb_x;
    logic [YW-1:0]  nb_y;
    logic           nb_off;
    logic [1:0]     req_dir_q, dir_q;
    logic           off_map_q;
    logic [XW-1:0]  tile_x_q, query_x_q;
    logic [YW-1:0]  tile_y_q, query_y_q;
    logic [OW-1:0]  offset_q, off_next;
    logic           anim_q;
    logic [9:0]     pix_x_q, pix_y_q, pix_x_d, pix_y_d;

    // Two flops resynchronise vsync; the third remembers the previous level for edge detection.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) fc_sync_q <= 3'b000;
        else          fc_sync_q <= {fc_sync_q[1], fc_sync_q[0], frame_clk};
    end
    assign tick = fc_sync_q[1] & ~fc_sync_q[2];

    always_comb begin
        key_req = 1'b1;
        key_dir = DIR_DOWN;
        if      (keycode == KEY_DOWN)  key_dir = DIR_DOWN;
        else if (keycode == KEY_UP)    key_dir = DIR_UP;
        else if (keycode == KEY_LEFT)  key_dir = DIR_LEFT;
        else if (keycode == KEY_RIGHT) key_dir = DIR_RIGHT;
        else                           key_req = 1'b0;
    end

    // Off-map targets fall back to the current tile so the lookup stays in range.
    always_comb begin
        nb_x   = tile_x_q;
        nb_y   = tile_y_q;
        nb_off = 1'b0;
        case (key_dir)
            DIR_DOWN:  if (tile_y_q == Y_MAX)    nb_off = 1'b1; else nb_y = tile_y_q + 1'b1;
            DIR_UP:    if (tile_y_q == '0)       nb_off = 1'b1; else nb_y = tile_y_q - 1'b1;
            DIR_LEFT:  if (tile_x_q == '0)       nb_off = 1'b1; else nb_x = tile_x_q - 1'b1;
            default:   if (tile_x_q == X_MAX)    nb_off = 1'b1; else nb_x = tile_x_q + 1'b1;
        endcase
    end

    assign off_next = offset_q + OFF_STEP;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tick && key_req) state_d = QUERY;
            QUERY:   state_d = CHECK;
            CHECK:   state_d = (Query_Blocked || off_map_q) ? IDLE : MOVE;
            MOVE:    if (tick && off_next >= OFF_FULL) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Query_Valid      = (state_q == QUERY);
        Character_Moving = (state_q == MOVE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            req_dir_q <= DIR_DOWN;
            dir_q     <= DIR_DOWN;
            off_map_q <= 1'b0;
            query_x_q <= '0;
            query_y_q <= '0;
            tile_x_q  <= XW'(START_X);
            tile_y_q  <= YW'(START_Y);
            offset_q  <= '0;
            anim_q    <= 1'b0;
        end else begin
            if (state_q == IDLE && tick && key_req) begin
                req_dir_q <= key_dir;
                off_map_q <= nb_off;
                query_x_q <= nb_x;
                query_y_q <= nb_y;
            end
            if (state_q == CHECK) dir_q <= req_dir_q;
            if (state_q == MOVE && tick) begin
                if (off_next >= OFF_FULL) begin
                    tile_x_q <= query_x_q;
                    tile_y_q <= query_y_q;
                    offset_q <= '0;
                    anim_q   <= ~anim_q;
                end else begin
                    offset_q <= off_next;
                    if (off_next >= OFF_HALF && offset_q < OFF_HALF) anim_q <= ~anim_q;
                end
            end
        end
    end

    always_comb begin
        pix_x_d = 10'(tile_x_q) * TILE10;
        pix_y_d = 10'(tile_y_q) * TILE10;
        case (dir_q)
            DIR_RIGHT: pix_x_d = pix_x_d + 10'(offset_q);
            DIR_LEFT:  pix_x_d = pix_x_d - 10'(offset_q);
            DIR_DOWN:  pix_y_d = pix_y_d + 10'(offset_q);
            default:   pix_y_d = pix_y_d - 10'(offset_q);
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pix_x_q <= 10'(START_X * TILE_PX);
            pix_y_q <= 10'(START_Y * TILE_PX);
        end else begin
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
        end
    end

    assign Query_X    = query_x_q;
    assign Query_Y    = query_y_q;
    assign Tile_X     = tile_x_q;
    assign Tile_Y     = tile_y_q;
    assign Pixel_X    = pix_x_q;
    assign Pixel_Y    = pix_y_q;
    assign Direction  = dir_q;
    assign Anim_Frame = anim_q;
endmodule

// File: tb/tb_tile_movement_ctrl.sv
// tb/tb_tile_movement_ctrl.sv - self-checking bench for tile_movement_ctrl
module tb_tile_movement_ctrl;
    logic       clk = 1'b0;
    logic       rst_n, rst_edge_n, frame_clk, qblk;
    logic [7:0] keycode;
    logic       qv, mov, anim;
    logic [4:0] qx, tx;
    logic [3:0] qy, ty;
    logic [9:0] px, py;
    logic [1:0] dir;
    logic       e_qv, e_mov, e_anim;
    logic [4:0] e_qx, e_tx;
    logic [3:0] e_qy, e_ty;
    logic [9:0] e_px, e_py;
    logic [1:0] e_dir;

    int total = 0;
    int bad = 0;
    int q_cnt = 0;
    bit pend = 1'b0;
    bit block_en = 1'b0;
    bit check_en = 1'b0;

    int m_tx, m_ty, m_off, m_dir, m_moving, m_anim, m_qx, m_qy, m_gx, m_gy;
    int m_queries = 0;

    always #5 clk = ~clk;

    tile_movement_ctrl u_dut (
        .Clk(clk), .Reset_n(rst_n), .frame_clk(frame_clk), .keycode(keycode),
        .Query_Blocked(qblk), .Query_Valid(qv), .Query_X(qx), .Query_Y(qy),
        .Tile_X(tx), .Tile_Y(ty), .Pixel_X(px), .Pixel_Y(py), .Direction(dir),
        .Character_Moving(mov), .Anim_Frame(anim)
    );

    tile_movement_ctrl #(.START_X(0)) u_edge (
        .Clk(clk), .Reset_n(rst_edge_n), .frame_clk(frame_clk), .keycode(keycode),
        .Query_Blocked(1'b0), .Query_Valid(e_qv), .Query_X(e_qx), .Query_Y(e_qy),
        .Tile_X(e_tx), .Tile_Y(e_ty), .Pixel_X(e_px), .Pixel_Y(e_py), .Direction(e_dir),
        .Character_Moving(e_mov), .Anim_Frame(e_anim)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task model_reset;
        m_tx = 10; m_ty = 7; m_off = 0; m_dir = 0; m_moving = 0; m_anim = 0;
        m_qx = 0; m_qy = 0; m_gx = 10; m_gy = 7;
    endtask

    // One frame tick of the tile-walk rules: finish/advance a step, or try to start one.
    task model_tick;
        int d, nx, ny;
        bit off;
        if (m_moving != 0) begin
            m_off += 2;
            if (m_off == 8) m_anim ^= 1;
            if (m_off == 16) begin
                m_anim ^= 1; m_tx = m_gx; m_ty = m_gy; m_off = 0; m_moving = 0;
            end
        end else begin
            case (keycode)
                8'h16:   d = 0;
                8'h1A:   d = 1;
                8'h04:   d = 2;
                8'h07:   d = 3;
                default: d = -1;
            endcase
            if (d >= 0) begin
                m_queries++;
                nx = m_tx + (d == 3 ? 1 : 0) - (d == 2 ? 1 : 0);
                ny = m_ty + (d == 0 ? 1 : 0) - (d == 1 ? 1 : 0);
                off = (nx < 0) || (nx > 19) || (ny < 0) || (ny > 14);
                if (off) begin nx = m_tx; ny = m_ty; end
                m_qx = nx; m_qy = ny; m_dir = d;
                if (!off && !block_en) begin m_moving = 1; m_gx = nx; m_gy = ny; end
            end
        end
    endtask

    function automatic int m_px();
        return m_tx * 16 + (m_dir == 3 ? m_off : 0) - (m_dir == 2 ? m_off : 0);
    endfunction

    function automatic int m_py();
        return m_ty * 16 + (m_dir == 0 ? m_off : 0) - (m_dir == 1 ? m_off : 0);
    endfunction

    // Collision responder: answers the cycle after the query pulse, low otherwise.
    always @(negedge clk) begin
        if (qv) q_cnt++;
        qblk = pend;
        pend = qv & block_en;
    end

    always @(posedge clk) begin
        #2;
        if (check_en) begin
            chk("tile_x", tx, m_tx);
            chk("tile_y", ty, m_ty);
            chk("pixel_x", px, m_px());
            chk("pixel_y", py, m_py());
            chk("direction", dir, m_dir);
            chk("moving", mov, m_moving);
            chk("anim", anim, m_anim);
            chk("query_x", qx, m_qx);
            chk("query_y", qy, m_qy);
            chk("query_valid_idle", qv, 0);
            chk("query_count", q_cnt, m_queries);
        end
    end

    task do_tick;
        frame_clk = 1'b1;
        repeat (6) @(negedge clk);
        frame_clk = 1'b0;
        model_tick();
        check_en = 1'b1;
        repeat (10) @(negedge clk);
        check_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rst_edge_n = 1'b0; frame_clk = 1'b0; keycode = 8'h00; qblk = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_tile_x", tx, 10); chk("rst_tile_y", ty, 7);
        chk("rst_pixel_x", px, 160); chk("rst_pixel_y", py, 112);
        chk("rst_dir", dir, 0); chk("rst_moving", mov, 0); chk("rst_anim", anim, 0);

        keycode = 8'h07;
        do_tick();
        chk("right_qx", qx, 11); chk("right_qy", qy, 7);
        chk("right_moving", mov, 1); chk("right_qcnt", q_cnt, 1);
        for (int k = 1; k <= 8; k++) begin
            do_tick();
            chk("right_pixel_x", px, 160 + 2 * k);
            if (k == 4) chk("anim_half", anim, 1);
        end
        chk("right_tile_x", tx, 11); chk("right_done_moving", mov, 0); chk("right_anim", anim, 0);
        do_tick();
        chk("walk_qx", qx, 12); chk("walk_moving", mov, 1); chk("walk_qcnt", q_cnt, 2);
        keycode = 8'h00;
        repeat (8) do_tick();
        chk("walk_tile_x", tx, 12); chk("walk_pixel_x", px, 192);

        block_en = 1'b1; keycode = 8'h1A;
        do_tick();
        chk("blk_dir", dir, 1); chk("blk_moving", mov, 0); chk("blk_tile_y", ty, 7);
        chk("blk_pixel_y", py, 112); chk("blk_qy", qy, 6); chk("blk_qcnt", q_cnt, 3);
        block_en = 1'b0; keycode = 8'h00;

        rst_edge_n = 1'b1;
        repeat (4) @(negedge clk);
        keycode = 8'h04;
        do_tick();
        keycode = 8'h00;
        chk("edge_dir", e_dir, 2); chk("edge_qx", e_qx, 0); chk("edge_qy", e_qy, 7);
        chk("edge_tile_x", e_tx, 0); chk("edge_moving", e_mov, 0); chk("edge_pixel_x", e_px, 0);
        repeat (8) do_tick();
        chk("left_tile_x", tx, 11);

        keycode = 8'h16;
        do_tick();
        keycode = 8'h00;
        repeat (8) do_tick();
        chk("down_tile_y", ty, 8); chk("down_pixel_y", py, 128);
        repeat (2) do_tick();
        chk("down_no_requery", q_cnt, 5);

        keycode = 8'h07;
        do_tick();
        keycode = 8'h00;
        repeat (3) do_tick();
        chk("mid_pixel_x", px, 182);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_tile_x", tx, 10); chk("arst_tile_y", ty, 7);
        chk("arst_pixel_x", px, 160); chk("arst_pixel_y", py, 112);
        chk("arst_moving", mov, 0); chk("arst_anim", anim, 0); chk("arst_dir", dir, 0);
        chk("arst_qx", qx, 0); chk("arst_qv", qv, 0);
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_tick();
        chk("post_rst_qcnt", q_cnt, 6); chk("post_rst_tile_x", tx, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tile_movement_ctrl.md
Name: tile_movement_ctrl

Overview:
- Parametrised successor to the character movement block.
- Converts the USB keycode into grid-locked, Pokemon-style tile steps for the player sprite, advancing on each VGA frame tick.
- Asks the map/collision logic whether the target tile is blocked, using a one-cycle query handshake.
- Drives the color mapper with direction, moving flag, walk-animation phase and pixel position.

Parameters:
- MAP_W, 20, map width in tiles
- MAP_H, 15, map height in tiles
- TILE_PX, 16, tile edge in pixels; must be a multiple of STEP_PX
- STEP_PX, 2, pixels advanced per frame tick while moving
- START_X, 10, reset tile column
- START_Y, 7, reset tile row
- KEY_UP / KEY_LEFT / KEY_DOWN / KEY_RIGHT, 8'h1A / 8'h04 / 8'h16 / 8'h07, HID keycodes (W/A/S/D)

Ports:
- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  VGA vertical sync; asynchronous to the logic, sampled on Clk
- keycode  in  8  current HID keycode; 0 means no key
- Query_Blocked  in  1  collision answer, valid the cycle after Query_Valid
- Query_Valid  out  1  one-cycle pulse requesting a collision lookup
- Query_X  out  $clog2(MAP_W)  target tile column
- Query_Y  out  $clog2(MAP_H)  target tile row
- Tile_X  out  $clog2(MAP_W)  committed tile column
- Tile_Y  out  $clog2(MAP_H)  committed tile row
- Pixel_X  out  10  sprite top-left x position in pixels
- Pixel_Y  out  10  sprite top-left y position in pixels
- Direction  out  2  facing: 0 down, 1 up, 2 left, 3 right
- Character_Moving  out  1  high while a step is in progress
- Anim_Frame  out  1  walk-cycle phase

Behaviour:
- Reset (async, Reset_n low): state IDLE; Tile_X/Tile_Y = START_X/START_Y; offset 0; Direction 0; Character_Moving 0; Anim_Frame 0; Query_Valid 0; Query_X/Query_Y = 0. Assert mid-step → immediate return to these values; the partial step is discarded.
- Frame tick: frame_clk passes through a 2-flop synchroniser; tick = one-Clk pulse on its rising edge. All movement timing counts ticks only.
- Key decode: matching one of the four KEY_* parameters gives a requested direction. Any other keycode, or 0, is no request.
- IDLE:
  - On tick with a request: latch req_dir, go to QUERY.
  - On tick without a request: stay in IDLE.
- QUERY (1 cycle):
  - Pulse Query_Valid.
  - Query_X/Query_Y = neighbour of Tile_X/Tile_Y in req_dir.
  - If the neighbour is off the map (column 0 going left, MAP_W-1 going right, row 0 going up, MAP_H-1 going down), Query_X/Query_Y hold the current tile. The lookup is still pulsed but its result is ignored.
  - Next state is CHECK.
- CHECK (1 cycle): sample Query_Blocked.
  - Direction <= req_dir unconditionally, so a blocked step still turns the sprite to face.
  - Blocked or off-map: return to IDLE, no motion.
  - Otherwise go to MOVE and set Character_Moving = 1.
- MOVE: each tick adds STEP_PX to offset (width $clog2(TILE_PX)+1).
  - Anim_Frame toggles when offset first reaches TILE_PX/2 and again on step completion.
  - When offset reaches TILE_PX: commit Tile_X/Tile_Y to the neighbour, clear offset to 0, drop Character_Moving, go to IDLE.
  - A step takes TILE_PX/STEP_PX ticks (default 8).
  - Keycode changes or release during MOVE are ignored; the step always completes.
  - A held key starts the next step at the following tick (continuous walking).
- Pixel output:
  - Pixel_X = Tile_X*TILE_PX ± offset in the x direction when moving horizontally; Pixel_Y likewise in y.
  - Sign follows Direction: + for right/down, − for left/up.
  - Computed in 10 bits, registered, 1-cycle latency.
- Simultaneous events:
  - A tick arriving in QUERY/CHECK is lost; the controller waits for the next tick.
  - Reset dominates everything.
- Query_Valid is never asserted outside QUERY. Query_X/Query_Y hold their last value elsewhere.

Test Plan:
- Reset release → Tile=(10,7), Pixel=(160,112), Direction=0, Moving=0, Anim_Frame=0.
- keycode=0x07 held, Query_Blocked=0, 8 ticks →
  - Query pulse with Query_X=11, Query_Y=7; Moving high.
  - Pixel_X=162,164,…,176.
  - Tile_X=11, Moving low; Anim_Frame toggled twice.
- keycode=0x1A with Query_Blocked=1 → Direction=1, Moving stays 0, Tile unchanged, Pixel unchanged.
- Start at tile column 0 (START_X=0), keycode=0x04 → no motion, Direction=2, Query_X=0.
- keycode=0x16 for 1 tick then 0 →
  - Full 8-tick step completes; Tile_Y=8, Pixel_Y=128.
  - Idle afterwards, no further query.
- Reset_n low after 3 ticks of a step → outputs return asynchronously to the reset values; no query follows release until the next keyed tick.
